// File: rtl/inv_permutation_func.sv
// Inverse Keccak pi (and optionally rho) over a 64-line 5x5x64 frame held in an external line memory.
// Define INV_RHO_EN to apply inverse rho after inverse pi; otherwise only inverse pi is applied.
module inv_permutation_func (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [24:0] line_in,
    output logic        done,
    output logic [5:0]  cnt_value,
    output logic        write_enable,
    output logic [24:0] write_value
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    state_e             state_q;
    logic [63:0][24:0]  lines_q;
    logic [63:0][24:0]  result_q;
    logic [63:0][24:0]  result_d;
    logic [5:0]         cnt_q;
    logic               phase_q;
    logic               done_q;
    logic               we_q;
    logic [24:0]        wv_q;

`ifdef INV_RHO_EN
    // Rotation offset of lane index 5*y+x.
    function automatic logic [5:0] rho_off(input int idx);
        case (idx)
            0:       rho_off = 6'd0;
            1:       rho_off = 6'd1;
            2:       rho_off = 6'd62;
            3:       rho_off = 6'd28;
            4:       rho_off = 6'd27;
            5:       rho_off = 6'd36;
            6:       rho_off = 6'd44;
            7:       rho_off = 6'd6;
            8:       rho_off = 6'd55;
            9:       rho_off = 6'd20;
            10:      rho_off = 6'd3;
            11:      rho_off = 6'd10;
            12:      rho_off = 6'd43;
            13:      rho_off = 6'd25;
            14:      rho_off = 6'd39;
            15:      rho_off = 6'd41;
            16:      rho_off = 6'd45;
            17:      rho_off = 6'd15;
            18:      rho_off = 6'd21;
            19:      rho_off = 6'd8;
            20:      rho_off = 6'd18;
            21:      rho_off = 6'd2;
            22:      rho_off = 6'd61;
            23:      rho_off = 6'd56;
            24:      rho_off = 6'd14;
            default: rho_off = 6'd0;
        endcase
    endfunction
`endif

    // Pure rewiring: A[x][y][z] = B[y][(2x+3y)%5][(z+r)%64], with r=0 when rho is disabled.
    always_comb begin
        result_d = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                for (int z = 0; z < 64; z++) begin
`ifdef INV_RHO_EN
                    result_d[z][5*y+x] = lines_q[(z + int'(rho_off(5*y+x))) % 64][5*((2*x+3*y) % 5) + y];
`else
                    result_d[z][5*y+x] = lines_q[z][5*((2*x+3*y) % 5) + y];
`endif
                end
            end
        end
    end

    // Frame sequencer with registered memory address and write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lines_q  <= '0;
            result_q <= '0;
            cnt_q    <= 6'd0;
            phase_q  <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            wv_q     <= 25'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    we_q   <= 1'b0;
                    wv_q   <= 25'd0;
                    cnt_q  <= 6'd0;
                    if (start) begin
                        state_q <= S_LOAD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    lines_q[cnt_q] <= line_in;
                    cnt_q          <= cnt_q + 6'd1;
                    if (cnt_q == 6'd63) begin
                        state_q <= S_COMPUTE;
                    end else begin
                        state_q <= S_LOAD;
                    end
                end
                S_COMPUTE: begin
                    // Line 0 is taken straight from the combinational result so its pulse lands on WRITE entry.
                    result_q <= result_d;
                    we_q     <= 1'b1;
                    wv_q     <= result_d[0];
                    cnt_q    <= 6'd0;
                    phase_q  <= 1'b0;
                    state_q  <= S_WRITE;
                end
                S_WRITE: begin
                    if (!phase_q) begin
                        we_q    <= 1'b0;
                        wv_q    <= 25'd0;
                        phase_q <= 1'b1;
                    end else if (cnt_q == 6'd63) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        cnt_q   <= 6'd0;
                        phase_q <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + 6'd1;
                        we_q    <= 1'b1;
                        wv_q    <= result_q[cnt_q + 6'd1];
                        phase_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    we_q    <= 1'b0;
                    wv_q    <= 25'd0;
                    cnt_q   <= 6'd0;
                    phase_q <= 1'b0;
                end
            endcase
        end
    end

    assign done         = done_q;
    assign cnt_value    = cnt_q;
    assign write_enable = we_q;
    assign write_value  = wv_q;

endmodule
